cam_bram_ternary: RTL and testbench
===================================

# cam_bram_ternary

Ternary content-addressable memory built from block-RAM slices, the masked successor of the binary BRAM CAM. Each entry stores data plus a per-bit care mask, so one entry can match many search keys. Searches run every cycle through a `compare_valid`/`match_valid` pipeline. Writes and deletes use a `write_valid`/`write_ready` handshake and an internal sweep that rewrites one bit column across every slice RAM. It sits in lookup datapaths as a classifier or wildcard filter in front of the priority-encoded match logic.

## Interface
Parameters:
- DATA_WIDTH, 64, search key width in bits.
- ADDR_WIDTH, 5, log2 of the number of entries; RAM_DEPTH = 2**ADDR_WIDTH.
- SLICE_WIDTH, 9, key bits per slice RAM. SLICE_COUNT = ceil(DATA_WIDTH/SLICE_WIDTH). Last slice width W_last = DATA_WIDTH - SLICE_WIDTH*(SLICE_COUNT-1).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- write_addr  in  ADDR_WIDTH  entry index to write or delete.
- write_data  in  DATA_WIDTH  entry value.
- write_mask  in  DATA_WIDTH  care mask; 1 = bit compared, 0 = wildcard.
- write_delete  in  1  1 = invalidate the entry; data and mask are ignored.
- write_valid  in  1  write request.
- write_ready  out  1  request accepted when valid && ready.
- compare_data  in  DATA_WIDTH  search key.
- compare_valid  in  1  search request.
- match_valid  out  1  qualifies all match outputs.
- match_many  out  RAM_DEPTH  one bit per matching entry.
- match_single  out  RAM_DEPTH  one-hot lowest-index match.
- match_addr  out  ADDR_WIDTH  lowest-index matching entry.
- match  out  1  at least one entry matched.

## Operation
- Storage: slice s is a dual-port RAM, 2**W_s words deep and RAM_DEPTH bits wide. Bit e of word a is 1 when entry e accepts key slice value a.
- Port A is read-only and serves the search. Port B serves the sweep with read-modify-write.
- Search:
  - Port A address = compare_data slice s.
  - match_many = AND of all slice words.
  - The priority encoder gives lowest-index priority.
  - Searches are never stalled.
- State machine: INIT, IDLE, SWEEP_RD, SWEEP_WR.
  - INIT: after rst, sweep counter c runs 0 .. 2**SLICE_WIDTH-1, writing all-zero words to every slice at address c. Then go to IDLE.
  - IDLE: write_ready=1. On a handshake, latch addr/data/mask/delete, set c=0, go to SWEEP_RD.
  - SWEEP_RD: port B reads address c[W_s-1:0] in every slice. Go to SWEEP_WR.
  - SWEEP_WR: for each slice, write back the read word with bit write_addr_reg replaced by hit_s. hit_s = !delete && ((c ^ data_s) & mask_s) == 0. Slice s writes only when c < 2**W_s. If c is the last count, go to IDLE; otherwise c++ and go to SWEEP_RD.
- Entry coverage:
  - Only the target column changes; other entries' bits are written back unchanged.
  - An all-zero mask matches every key.
  - Delete clears the column, so the entry never matches.
- rst in any state: abort the sweep, go to INIT, drop in-flight search results (match_valid=0 next cycle).
- Reset and write_valid in the same cycle: reset wins, and the request is not accepted.

## Timing
- Reset values: write_ready=0, match_valid=0, match=0, match_addr=0, match_many=0, match_single=0.
- write_ready rises 2**SLICE_WIDTH+1 cycles after rst deasserts.
- Write accepted at edge t:
  - write_ready is low from t+1.
  - The sweep takes 2*2**SLICE_WIDTH cycles.
  - write_ready returns high at t+2*2**SLICE_WIDTH+1.
- Search latency: compare sampled at edge t gives match_valid and results at t+1 (RAM read latency).
- Searches during a sweep: the result bit for the target entry is undefined (mix of old and new coverage). All other entries are exact.
- Searches issued after write_ready has returned high see the new entry.

## Configuration
- CAM_BRAM_TERNARY_OUT_REG_EN defined: register match_many, match_single, match_addr, match and match_valid after the encoder. Search latency becomes 2 cycles; reset values are unchanged.
- Undefined: outputs are combinational from the RAM outputs, with 1-cycle latency.

## Structure
- Package cam_pkg holds:
  - the sweep state enum (INIT, IDLE, SWEEP_RD, SWEEP_WR);
  - the function computing SLICE_COUNT and per-slice width.
- Sub-module ram_dp: one instance per slice from a generate loop.
- The existing priority_encoder instance does the encoding, with LSB_PRIORITY "HIGH".
- Sweep FSM and column-update logic stay in this module.

## Test plan
Bench config: DATA_WIDTH=16, ADDR_WIDTH=3, SLICE_WIDTH=8, macro undefined.
- Reset, then idle: write_ready low for 257 cycles, then high; any search gives match=0, match_many=8'h00.
- Write entry 2 with data=16'hAB00, mask=16'hFF00; search 16'hAB5C, then 16'hAC00:
  - 16'hAB5C: match=1, match_addr=2, match_many=8'h04.
  - 16'hAC00: match=0.
- Write entry 5 with mask=16'h0000 (any data), plus entry 2 from above; search 16'hAB00: match_many=8'h24, match_single=8'h04, match_addr=2.
- Delete entry 2, then search 16'hAB00: match_many=8'h20, match_addr=5. write_ready is low for exactly 512 cycles.
- Overwrite entry 5 with data=16'h1234, mask=16'hFFFF:
  - 16'h1234 matches entry 5 only.
  - 16'h9999 gives match=0, proving the old wildcard coverage is fully removed.
- Assert rst mid-sweep (cycle 100 of a write): write_ready=0 and match_valid=0 next cycle, INIT reruns, and every later search returns match=0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and sizing helpers for the ternary BRAM CAM.
package cam_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        IDLE     = 2'd1,
        SWEEP_RD = 2'd2,
        SWEEP_WR = 2'd3
    } sweep_state_e;

    function automatic int slice_count(int dataWidth, int sliceWidth);
        return (dataWidth + sliceWidth - 1) / sliceWidth;
    endfunction

    // Every slice is sliceWidth bits wide except the last, which takes the remainder.
    function automatic int slice_width(int dataWidth, int sliceWidth, int idx);
        int count;
        count = slice_count(dataWidth, sliceWidth);
        if (idx == count - 1) begin
            return dataWidth - sliceWidth * (count - 1);
        end
        return sliceWidth;
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// Priority encoder; LSB_PRIORITY "HIGH" makes the lowest set index win.
module priority_encoder #(
    parameter int WIDTH        = 8,
    parameter     LSB_PRIORITY = "HIGH"
) (
    input  logic [WIDTH-1:0]         input_unencoded_i,
    output logic                     output_valid_o,
    output logic [$clog2(WIDTH)-1:0] output_encoded_o,
    output logic [WIDTH-1:0]         output_unencoded_o
);

    localparam int ENC_W = $clog2(WIDTH);

    always_comb begin
        output_valid_o   = 1'b0;
        output_encoded_o = '0;
        if (LSB_PRIORITY == "HIGH") begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (input_unencoded_i[i]) begin
                    output_valid_o   = 1'b1;
                    output_encoded_o = ENC_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (input_unencoded_i[i]) begin
                    output_valid_o   = 1'b1;
                    output_encoded_o = ENC_W'(i);
                end
            end
        end
        output_unencoded_o = output_valid_o ? (WIDTH'(1) << output_encoded_o) : '0;
    end

endmodule

// File: rtl/ram_dp.sv
// Simple dual-port RAM: port A read-only, port B read-first read/write, both registered.
module ram_dp #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] a_addr_i,
    output logic [DATA_W-1:0] a_dout_o,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_din_i,
    output logic [DATA_W-1:0] b_dout_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        a_dout_o <= mem_q[a_addr_i];
        b_dout_o <= mem_q[b_addr_i];
        if (b_we_i) begin
            mem_q[b_addr_i] <= b_din_i;
        end
    end

endmodule

// File: rtl/cam_bram_ternary.sv
// Ternary CAM over per-slice dual-port RAMs; writes sweep one entry column through every slice.
// Define CAM_BRAM_TERNARY_OUT_REG_EN to register the match outputs after the encoder (2-cycle search).
module cam_bram_ternary
    import cam_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 5,
    parameter int SLICE_WIDTH = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      write_addr,
    input  logic [DATA_WIDTH-1:0]      write_data,
    input  logic [DATA_WIDTH-1:0]      write_mask,
    input  logic                       write_delete,
    input  logic                       write_valid,
    output logic                       write_ready,
    input  logic [DATA_WIDTH-1:0]      compare_data,
    input  logic                       compare_valid,
    output logic                       match_valid,
    output logic [2**ADDR_WIDTH-1:0]   match_many,
    output logic [2**ADDR_WIDTH-1:0]   match_single,
    output logic [ADDR_WIDTH-1:0]      match_addr,
    output logic                       match
);

    localparam int RAM_DEPTH   = 2**ADDR_WIDTH;
    localparam int SLICE_COUNT = slice_count(DATA_WIDTH, SLICE_WIDTH);

    sweep_state_e            state_q, state_d;
    logic [SLICE_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   wrAddr_q, wrAddr_d;
    logic [DATA_WIDTH-1:0]   wrData_q, wrData_d;
    logic [DATA_WIDTH-1:0]   wrMask_q, wrMask_d;
    logic                    wrDelete_q, wrDelete_d;
    logic                    lastCount;
    logic                    initWr;
    logic                    sweepWr;
    logic                    searchValid_q;
    logic [RAM_DEPTH-1:0]    sliceWord [SLICE_COUNT];
    logic [RAM_DEPTH-1:0]    andWord;
    logic [RAM_DEPTH-1:0]    hitMany;
    logic                    encValid;
    logic [ADDR_WIDTH-1:0]   encAddr;
    logic [RAM_DEPTH-1:0]    encSingle;

    assign lastCount = (cnt_q == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            wrAddr_q   <= '0;
            wrData_q   <= '0;
            wrMask_q   <= '0;
            wrDelete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wrAddr_q   <= wrAddr_d;
            wrData_q   <= wrData_d;
            wrMask_q   <= wrMask_d;
            wrDelete_q <= wrDelete_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wrAddr_d   = wrAddr_q;
        wrData_d   = wrData_q;
        wrMask_d   = wrMask_q;
        wrDelete_d = wrDelete_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (lastCount) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (write_valid && write_ready) begin
                    wrAddr_d   = write_addr;
                    wrData_d   = write_data;
                    wrMask_d   = write_mask;
                    wrDelete_d = write_delete;
                    cnt_d      = '0;
                    state_d    = SWEEP_RD;
                end
            end
            SWEEP_RD: begin
                state_d = SWEEP_WR;
            end
            SWEEP_WR: begin
                if (lastCount) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = SWEEP_RD;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Holding ready low during rst guarantees a request in the reset cycle is never accepted.
    always_comb begin
        write_ready = (state_q == IDLE) && !rst;
        initWr      = (state_q == INIT);
        sweepWr     = (state_q == SWEEP_WR);
    end

    for (genvar s = 0; s < SLICE_COUNT; s++) begin : g_slice
        localparam int SW = slice_width(DATA_WIDTH, SLICE_WIDTH, s);
        localparam int LO = s * SLICE_WIDTH;

        logic [SW-1:0]        colAddr;
        logic [SW-1:0]        keySlice;
        logic [SW-1:0]        dataSlice;
        logic [SW-1:0]        maskSlice;
        logic                 inRange;
        logic                 hit;
        logic                 portBWe;
        logic [RAM_DEPTH-1:0] rdWord;
        logic [RAM_DEPTH-1:0] wrWord;

        assign colAddr   = cnt_q[SW-1:0];
        assign keySlice  = compare_data[LO +: SW];
        assign dataSlice = wrData_q[LO +: SW];
        assign maskSlice = wrMask_q[LO +: SW];

        // A narrower last slice only owns the low part of the shared counter range.
        if (SW < SLICE_WIDTH) begin : g_partial
            assign inRange = (cnt_q[SLICE_WIDTH-1:SW] == '0);
        end else begin : g_full
            assign inRange = 1'b1;
        end

        assign hit     = !wrDelete_q && (((colAddr ^ dataSlice) & maskSlice) == '0);
        assign portBWe = (initWr || sweepWr) && inRange;

        always_comb begin
            wrWord           = rdWord;
            wrWord[wrAddr_q] = hit;
            if (initWr) begin
                wrWord = '0;
            end
        end

        ram_dp #(
            .ADDR_W (SW),
            .DATA_W (RAM_DEPTH)
        ) u_ram (
            .clk      (clk),
            .a_addr_i (keySlice),
            .a_dout_o (sliceWord[s]),
            .b_we_i   (portBWe),
            .b_addr_i (colAddr),
            .b_din_i  (wrWord),
            .b_dout_o (rdWord)
        );
    end

    always_comb begin
        andWord = '1;
        for (int s = 0; s < SLICE_COUNT; s++) begin
            andWord &= sliceWord[s];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            searchValid_q <= 1'b0;
        end else begin
            searchValid_q <= compare_valid;
        end
    end

    assign hitMany = searchValid_q ? andWord : '0;

    priority_encoder #(
        .WIDTH        (RAM_DEPTH),
        .LSB_PRIORITY ("HIGH")
    ) u_enc (
        .input_unencoded_i  (hitMany),
        .output_valid_o     (encValid),
        .output_encoded_o   (encAddr),
        .output_unencoded_o (encSingle)
    );

`ifdef CAM_BRAM_TERNARY_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            match_valid  <= 1'b0;
            match_many   <= '0;
            match_single <= '0;
            match_addr   <= '0;
            match        <= 1'b0;
        end else begin
            match_valid  <= searchValid_q;
            match_many   <= hitMany;
            match_single <= encSingle;
            match_addr   <= encAddr;
            match        <= encValid;
        end
    end
`else
    always_comb begin
        match_valid  = searchValid_q;
        match_many   = hitMany;
        match_single = encSingle;
        match_addr   = encAddr;
        match        = encValid;
    end
`endif

endmodule

// File: tb/tb_cam_bram_ternary.sv
// Self-checking bench for cam_bram_ternary (16-bit keys, 8 entries, 8-bit slices, default build).
module tb_cam_bram_ternary;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int SW    = 8;
    localparam int DEPTH = 8;

    logic            clk;
    logic            rst;
    logic [AW-1:0]   write_addr;
    logic [DW-1:0]   write_data;
    logic [DW-1:0]   write_mask;
    logic            write_delete;
    logic            write_valid;
    logic            write_ready;
    logic [DW-1:0]   compare_data;
    logic            compare_valid;
    logic            match_valid;
    logic [DEPTH-1:0] match_many;
    logic [DEPTH-1:0] match_single;
    logic [AW-1:0]   match_addr;
    logic            match;

    int total = 0;
    int bad   = 0;

    // Entry-level reference: which entries exist and what they cover.
    logic            mValid [DEPTH];
    logic [DW-1:0]   mData  [DEPTH];
    logic [DW-1:0]   mMask  [DEPTH];
    int              initCount = 0;
    int              pendCount = 0;
    logic [AW-1:0]   pendAddr  = '0;
    logic [DW-1:0]   pendData  = '0;
    logic [DW-1:0]   pendMask  = '0;
    logic            pendDel   = 1'b0;
    logic            modelLive = 1'b0;
    logic            readyN    = 1'b0;
    logic            expValid  = 1'b0;
    logic [DEPTH-1:0] expMany  = '0;
    logic [DEPTH-1:0] expUndef = '0;

    cam_bram_ternary #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .SLICE_WIDTH (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .write_mask    (write_mask),
        .write_delete  (write_delete),
        .write_valid   (write_valid),
        .write_ready   (write_ready),
        .compare_data  (compare_data),
        .compare_valid (compare_valid),
        .match_valid   (match_valid),
        .match_many    (match_many),
        .match_single  (match_single),
        .match_addr    (match_addr),
        .match         (match)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [DEPTH-1:0] modelMany(input logic [DW-1:0] key);
        logic [DEPTH-1:0] r;
        r = '0;
        for (int e = 0; e < DEPTH; e++) begin
            r[e] = mValid[e] && (((key ^ mData[e]) & mMask[e]) == '0);
        end
        return r;
    endfunction

    // Reference update on each rising edge; entries under a sweep or an INIT pass are don't-care.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            modelLive = 1'b1;
            expValid  = 1'b0;
            initCount = 2**SW;
            pendCount = 0;
            for (int e = 0; e < DEPTH; e++) begin
                mValid[e] = 1'b0;
                mData[e]  = '0;
                mMask[e]  = '0;
            end
        end else if (modelLive) begin
            expValid = compare_valid;
            expMany  = modelMany(compare_data);
            if (initCount > 0) begin
                expUndef = '1;
            end else if (pendCount > 0) begin
                expUndef = DEPTH'(1) << pendAddr;
            end else begin
                expUndef = '0;
            end
            if (initCount > 0) begin
                initCount--;
            end
            if (pendCount > 0) begin
                pendCount--;
                if (pendCount == 0) begin
                    mValid[pendAddr] = !pendDel;
                    mData[pendAddr]  = pendData;
                    mMask[pendAddr]  = pendMask;
                end
            end
            if (write_valid && readyN) begin
                pendAddr  = write_addr;
                pendData  = write_data;
                pendMask  = write_mask;
                pendDel   = write_delete;
                pendCount = 2 * (2**SW);
            end
        end
    end

    initial forever begin
        int lo;
        @(negedge clk);
        readyN = write_ready;
        if (modelLive) begin
            checkOutput("cmp_match_valid", 32'(match_valid), 32'(expValid));
            if (expValid && expUndef != '1) begin
                checkOutput("cmp_match_many", 32'(match_many & ~expUndef), 32'(expMany & ~expUndef));
                if (expUndef == '0) begin
                    lo = -1;
                    for (int e = DEPTH - 1; e >= 0; e--) begin
                        if (expMany[e]) lo = e;
                    end
                    checkOutput("cmp_match", 32'(match), 32'(lo >= 0));
                    checkOutput("cmp_match_addr", 32'(match_addr), (lo >= 0) ? 32'(lo) : 32'd0);
                    checkOutput("cmp_match_single", 32'(match_single),
                                (lo >= 0) ? 32'(DEPTH'(1) << lo) : 32'd0);
                end
            end
        end
    end

    // One-cycle reset; counts negedge samples with write_ready low, starting with the rst cycle.
    task automatic resetDut(output int lowCnt);
        @(posedge clk);
        #1 rst = 1'b1;
        lowCnt = 0;
        @(negedge clk);
        checkOutput("rst_cycle_write_ready", 32'(write_ready), 32'd0);
        if (!write_ready) lowCnt++;
        @(posedge clk);
        #1 rst = 1'b0;
        compare_valid = 1'b0;
        @(negedge clk);
        checkOutput("reset_match_valid", 32'(match_valid), 32'd0);
        checkOutput("reset_match", 32'(match), 32'd0);
        checkOutput("reset_match_addr", 32'(match_addr), 32'd0);
        checkOutput("reset_match_many", 32'(match_many), 32'd0);
        checkOutput("reset_match_single", 32'(match_single), 32'd0);
        if (!write_ready) lowCnt++;
        repeat (2000) begin
            @(negedge clk);
            if (write_ready) break;
            lowCnt++;
        end
    endtask

    task automatic applyStimulus(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic [DW-1:0] m, input logic del);
        logic seen;
        seen = 1'b0;
        repeat (2000) begin
            @(negedge clk);
            if (write_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checkOutput("write_ready_timeout", 32'd0, 32'd1);
        end else begin
            write_addr   = a;
            write_data   = d;
            write_mask   = m;
            write_delete = del;
            write_valid  = 1'b1;
            @(posedge clk);
            #1 write_valid = 1'b0;
        end
    endtask

    task automatic waitReady(output int lowCnt);
        lowCnt = 0;
        repeat (2000) begin
            @(negedge clk);
            if (write_ready) break;
            lowCnt++;
        end
    endtask

    task automatic doSearch(input logic [DW-1:0] key, output logic [DEPTH-1:0] many,
                            output logic [DEPTH-1:0] single, output logic [AW-1:0] addr,
                            output logic hitAny);
        @(posedge clk);
        #1 compare_valid = 1'b1;
        compare_data = key;
        @(posedge clk);
        #1 compare_valid = 1'b0;
        @(negedge clk);
        many   = match_many;
        single = match_single;
        addr   = match_addr;
        hitAny = match;
    endtask

    initial begin
        int               lowCnt;
        logic [DEPTH-1:0] many;
        logic [DEPTH-1:0] single;
        logic [AW-1:0]    addr;
        logic             hitAny;

        rst           = 1'b1;
        write_addr    = '0;
        write_data    = '0;
        write_mask    = '0;
        write_delete  = 1'b0;
        write_valid   = 1'b0;
        compare_data  = '0;
        compare_valid = 1'b0;

        resetDut(lowCnt);
        checkOutput("init_ready_low_cycles", 32'(lowCnt), 32'd257);
        doSearch(16'h0000, many, single, addr, hitAny);
        checkOutput("empty_match", 32'(hitAny), 32'd0);
        checkOutput("empty_many", 32'(many), 32'h00);

        applyStimulus(3'd2, 16'hAB00, 16'hFF00, 1'b0);
        waitReady(lowCnt);
        checkOutput("write2_ready_low_cycles", 32'(lowCnt), 32'd512);
        doSearch(16'hAB5C, many, single, addr, hitAny);
        checkOutput("ab5c_match", 32'(hitAny), 32'd1);
        checkOutput("ab5c_addr", 32'(addr), 32'd2);
        checkOutput("ab5c_many", 32'(many), 32'h04);
        doSearch(16'hAC00, many, single, addr, hitAny);
        checkOutput("ac00_match", 32'(hitAny), 32'd0);

        applyStimulus(3'd5, 16'h5A5A, 16'h0000, 1'b0);
        waitReady(lowCnt);
        doSearch(16'hAB00, many, single, addr, hitAny);
        checkOutput("wild_many", 32'(many), 32'h24);
        checkOutput("wild_single", 32'(single), 32'h04);
        checkOutput("wild_addr", 32'(addr), 32'd2);

        applyStimulus(3'd2, 16'hFFFF, 16'hFFFF, 1'b1);
        waitReady(lowCnt);
        checkOutput("delete_ready_low_cycles", 32'(lowCnt), 32'd512);
        doSearch(16'hAB00, many, single, addr, hitAny);
        checkOutput("delete_many", 32'(many), 32'h20);
        checkOutput("delete_addr", 32'(addr), 32'd5);

        applyStimulus(3'd5, 16'h1234, 16'hFFFF, 1'b0);
        waitReady(lowCnt);
        doSearch(16'h1234, many, single, addr, hitAny);
        checkOutput("exact_many", 32'(many), 32'h20);
        checkOutput("exact_addr", 32'(addr), 32'd5);
        doSearch(16'h9999, many, single, addr, hitAny);
        checkOutput("old_wild_gone", 32'(hitAny), 32'd0);

        // Entry 3 never covers 16'h1234 before or after this write, so the result stays exact.
        applyStimulus(3'd3, 16'h00FF, 16'h00FF, 1'b0);
        repeat (45) @(posedge clk);
        doSearch(16'h1234, many, single, addr, hitAny);
        checkOutput("mid_sweep_many", 32'(many), 32'h20);
        checkOutput("mid_sweep_addr", 32'(addr), 32'd5);
        repeat (48) @(posedge clk);
        #1 compare_valid = 1'b1;
        compare_data = 16'h00FF;
        resetDut(lowCnt);
        checkOutput("rerun_init_low_cycles", 32'(lowCnt), 32'd257);
        doSearch(16'h1234, many, single, addr, hitAny);
        checkOutput("post_rst_1234", 32'(hitAny), 32'd0);
        doSearch(16'h00FF, many, single, addr, hitAny);
        checkOutput("post_rst_00ff", 32'(hitAny), 32'd0);
        doSearch(16'hAB00, many, single, addr, hitAny);
        checkOutput("post_rst_ab00_many", 32'(many), 32'h00);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
